cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: CPU PC width.
REQ-002 SHALL have parameter CNT_W, default 16: cycle-count width.
REQ-003 SHALL have parameter NUM_BP, default 2: breakpoint comparator count, 1..8.
REQ-004 SHALL have parameter RST_CYC, default 2: CPU reset hold length in cycles, >=1.
REQ-005 SHALL have port CLK, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1: command offered.
REQ-008 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
REQ-009 SHALL have port cmd_op, input, 2: 00 STEP, 01 RUN_N, 10 RUN_BP, 11 HALT.
REQ-010 SHALL have port cmd_count, input, CNT_W: RUN_N length; RUN_BP timeout (0 = unlimited).
REQ-011 SHALL have port PC_Value, input, ADDR_W: current CPU PC.
REQ-012 SHALL have port bp_addr, input, NUM_BP*ADDR_W: breakpoint addresses, slot i at bits [i*ADDR_W +: ADDR_W].
REQ-013 SHALL have port bp_en, input, NUM_BP: per-slot breakpoint enable.
REQ-014 SHALL have port cpu_rst, output, 1: CPU reset.
REQ-015 SHALL have port cpu_ce, output, 1: CPU clock enable; one high cycle = one CPU cycle.
REQ-016 SHALL have port halted, output, 1: high in IDLE.
REQ-017 SHALL have port bp_hit, output, NUM_BP: slots that matched at the last breakpoint stop.
REQ-018 SHALL have port steps_done, output, CNT_W: cpu_ce-high cycles since the last accepted command.
REQ-019 SHALL have port cmd_err, output, 1: one-cycle pulse when a command is discarded.

Function
REQ-020 SHALL implement FSM states RESET, IDLE, STEP, RUN_N, RUN_BP.
REQ-021 In RESET: cpu_rst=1, cpu_ce=1, cmd_ready=0; RESET SHALL advance to IDLE after RST_CYC cycles following RST deassertion.
REQ-022 In IDLE: cpu_ce=0, cmd_ready=1, halted=1.
REQ-023 Command accepted at cycle t; cpu_ce SHALL first be high at t+1; steps_done SHALL clear at t+1 and bp_hit SHALL clear at t+1.
REQ-024 STEP: cpu_ce high for exactly cycle t+1; SHALL return to IDLE at t+2.
REQ-025 RUN_N with count N>0: cpu_ce high for cycles t+1..t+N; SHALL return to IDLE at t+N+1.
REQ-026 RUN_N with N=0: SHALL be a no-op; SHALL remain in IDLE; steps_done SHALL stay unchanged.
REQ-027 RUN_BP: cpu_ce = !match, where match = OR over i of (bp_en[i] && PC_Value == bp slot i); match is combinational on PC_Value.
REQ-028 RUN_BP: match SHALL be ignored in the first RUN_BP cycle (resume from breakpoint).
REQ-029 RUN_BP on match: cpu_ce=0 in the match cycle; bp_hit SHALL latch the per-slot match vector; next state SHALL be IDLE.
REQ-030 RUN_BP with nonzero cmd_count: SHALL return to IDLE after cmd_count cpu_ce cycles; bp_hit SHALL be 0 on timeout.
REQ-031 HALT in IDLE: SHALL be a no-op with no cmd_err.
REQ-032 In STEP/RUN_N/RUN_BP: cmd_ready=1; HALT accepted at cycle t SHALL force cpu_ce=0 from t+1 and state IDLE at t+1.
REQ-033 In STEP/RUN_N/RUN_BP: a non-HALT command SHALL be consumed and discarded, and cmd_err SHALL pulse at t+1.
REQ-034 HALT coincident with the last RUN_N cycle or with a breakpoint match: the normal completion SHALL take priority; bp_hit SHALL still latch.
REQ-035 steps_done SHALL saturate at all-ones.

Reset
REQ-036 While RST=1: state=RESET, cpu_rst=1, cpu_ce=0, cmd_ready=0, halted=0, bp_hit=0, steps_done=0, cmd_err=0, counters=0.
REQ-037 RST asserted mid-run SHALL abort immediately; no completion or cmd_err event SHALL be produced.

Structure
REQ-038 Package cpu_run_pkg SHALL hold the op encodings (OP_STEP, OP_RUN_N, OP_RUN_BP, OP_HALT) and the state enum.
REQ-039 Sub-module cpu_bp_match SHALL implement the NUM_BP comparators and output the per-slot match vector.

Verification
REQ-040 RST pulse, RST_CYC=2 -> cpu_rst high through 2 cycles after release; cmd_ready=1 on 3rd cycle.
REQ-041 STEP -> exactly one cpu_ce cycle; steps_done=1; halted again at t+2.
REQ-042 RUN_N count=5 -> 5 cpu_ce cycles; steps_done=5; RUN_N count=0 -> no cpu_ce, steps_done unchanged.
REQ-043 bp_en=01, bp0=0x0000_0010, PC ramps 0x00,0x04,... under RUN_BP -> stop with PC=0x10; bp_hit=01; re-issue RUN_BP at PC 0x10 -> advances past 0x10.
REQ-044 RUN_N 100 then HALT at cycle 10 -> cpu_ce low from cycle 11; STEP mid-run -> cmd_err pulse, run continues.
REQ-045 RST asserted during RUN_BP -> cpu_ce=0 and cpu_rst=1 immediately; bp_hit=0.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run controller: host command opcodes and controller states.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        OP_STEP   = 2'b00,
        OP_RUN_N  = 2'b01,
        OP_RUN_BP = 2'b10,
        OP_HALT   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_STEP,
        ST_RUN_N,
        ST_RUN_BP
    } state_e;

endpackage

// File: rtl/cpu_bp_match.sv
// Breakpoint comparators: one equality compare of the live PC per enabled slot.
// Purely combinational, zero latency, no flow control.
module cpu_bp_match #(
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 2
) (
    input  logic [ADDR_W-1:0]        pc,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]        bp_en,
    output logic [NUM_BP-1:0]        match_vec
);

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_BP; i++)
            match_vec[i] = bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W]);
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Debug run controller: holds the CPU in reset, then single-steps, runs N cycles or runs to a breakpoint.
// cpu_ce rises the cycle after a command is accepted; commands are always taken outside RESET, extra ones are dropped with cmd_err.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int NUM_BP  = 2,
    parameter int RST_CYC = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_count,
    input  logic [ADDR_W-1:0]        PC_Value,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]        bp_en,
    output logic                     cpu_rst,
    output logic                     cpu_ce,
    output logic                     halted,
    output logic [NUM_BP-1:0]        bp_hit,
    output logic [CNT_W-1:0]         steps_done,
    output logic                     cmd_err
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_e            state;
    logic [RC_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]  remain;
    logic              limited;
    logic              first;
    logic [NUM_BP-1:0] match_vec;
    logic              match;
    logic              accept;
    logic              is_halt;
    logic              running;
    logic              ce_run;

    cpu_bp_match #(
        .ADDR_W (ADDR_W),
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .pc        (PC_Value),
        .bp_addr   (bp_addr),
        .bp_en     (bp_en),
        .match_vec (match_vec)
    );

    assign running   = (state == ST_STEP) || (state == ST_RUN_N) || (state == ST_RUN_BP);
    assign accept    = cmd_valid && cmd_ready;
    assign is_halt   = (op_e'(cmd_op) == OP_HALT);
    // The first RUN_BP cycle ignores the comparators so a run can resume from the breakpoint it stopped on.
    assign match     = (state == ST_RUN_BP) && !first && (|match_vec);
    assign ce_run    = (state == ST_STEP) || (state == ST_RUN_N) || ((state == ST_RUN_BP) && !match);
    assign cpu_ce    = ce_run || ((state == ST_RESET) && !RST);
    assign cpu_rst   = (state == ST_RESET);
    assign cmd_ready = (state != ST_RESET);
    assign halted    = (state == ST_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_RESET;
            rst_cnt    <= '0;
            remain     <= '0;
            limited    <= 1'b0;
            first      <= 1'b0;
            bp_hit     <= '0;
            steps_done <= '0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= running && accept && !is_halt;
            if (ce_run && (steps_done != '1))
                steps_done <= steps_done + 1'b1;

            case (state)
                ST_RESET: begin
                    if (rst_cnt == RC_W'(RST_CYC - 1))
                        state <= ST_IDLE;
                    else
                        rst_cnt <= rst_cnt + 1'b1;
                end
                ST_IDLE: begin
                    if (accept) begin
                        case (op_e'(cmd_op))
                            OP_STEP: begin
                                state      <= ST_STEP;
                                steps_done <= '0;
                                bp_hit     <= '0;
                            end
                            OP_RUN_N: begin
                                if (cmd_count != '0) begin
                                    state      <= ST_RUN_N;
                                    remain     <= cmd_count;
                                    steps_done <= '0;
                                    bp_hit     <= '0;
                                end
                            end
                            OP_RUN_BP: begin
                                state      <= ST_RUN_BP;
                                remain     <= cmd_count;
                                limited    <= (cmd_count != '0);
                                first      <= 1'b1;
                                steps_done <= '0;
                                bp_hit     <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STEP: state <= ST_IDLE;
                ST_RUN_N: begin
                    if ((remain == CNT_W'(1)) || (accept && is_halt))
                        state <= ST_IDLE;
                    else
                        remain <= remain - 1'b1;
                end
                ST_RUN_BP: begin
                    first <= 1'b0;
                    // A breakpoint stop outranks a coincident HALT so the hit vector is still recorded.
                    if (match) begin
                        bp_hit <= match_vec;
                        state  <= ST_IDLE;
                    end else if ((limited && (remain == CNT_W'(1))) || (accept && is_halt)) begin
                        state <= ST_IDLE;
                    end else if (limited) begin
                        remain <= remain - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a toy CPU whose PC advances by 4 per cpu_ce, directed steps plus random commands.
module tb_cpu_run_ctrl;
    import cpu_run_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 16;
    localparam int NUM_BP  = 2;
    localparam int RST_CYC = 2;

    logic                     CLK = 1'b0;
    logic                     RST = 1'b1;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_op;
    logic [CNT_W-1:0]         cmd_count;
    logic [ADDR_W-1:0]        PC_Value;
    logic [NUM_BP*ADDR_W-1:0] bp_addr;
    logic [NUM_BP-1:0]        bp_en;
    logic                     cpu_rst;
    logic                     cpu_ce;
    logic                     halted;
    logic [NUM_BP-1:0]        bp_hit;
    logic [CNT_W-1:0]         steps_done;
    logic                     cmd_err;

    cpu_run_ctrl #(
        .ADDR_W (ADDR_W), .CNT_W (CNT_W), .NUM_BP (NUM_BP), .RST_CYC (RST_CYC)
    ) dut (
        .CLK (CLK), .RST (RST), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_op (cmd_op), .cmd_count (cmd_count), .PC_Value (PC_Value),
        .bp_addr (bp_addr), .bp_en (bp_en), .cpu_rst (cpu_rst), .cpu_ce (cpu_ce),
        .halted (halted), .bp_hit (bp_hit), .steps_done (steps_done), .cmd_err (cmd_err)
    );

    always #5 CLK = ~CLK;

    logic [ADDR_W-1:0] pc = '0;
    always @(posedge CLK) begin
        if (cpu_rst)     pc <= '0;
        else if (cpu_ce) pc <= pc + 32'd4;
    end
    assign PC_Value = pc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ce_acc   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        ce_acc += int'(cpu_ce);
        @(negedge CLK);
    endtask

    // Present a command for one cycle (caller sits at a negedge); returns in the following cycle.
    task automatic send(input logic [1:0] op, input int cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CNT_W'(cnt);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            tick();
            cycles++;
        end
        check("idle_reached", halted, 1);
    endtask

    // Walk the PC positions reached after k enabled cycles; position k is only tested while the timeout allows.
    function automatic int bp_model(input logic [31:0] p0, input logic [31:0] a0, input logic [31:0] a1,
                                    input logic [1:0] en, input int tmo, output logic [1:0] hit);
        logic [31:0] p;
        hit = 2'b00;
        for (int k = 1; k < 200; k++) begin
            if (tmo != 0 && k >= tmo) return tmo;
            p = p0 + 32'(4 * k);
            hit[0] = en[0] && (a0 == p);
            hit[1] = en[1] && (a1 == p);
            if (hit != 2'b00) return k;
        end
        hit = 2'b00;
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, sel, n, tmo, steps;
        logic [31:0] exp_pc, a0, a1;
        logic [1:0]  en, hit_exp, hit_m;
        logic [CNT_W-1:0] sd_exp;

        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0; bp_addr = '0; bp_en = '0;

        // Held in reset
        repeat (3) @(negedge CLK);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_halted", halted, 0);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_steps_done", steps_done, 0);
        check("rst_cmd_err", cmd_err, 0);

        // Release: two cycles of CPU reset with clock enabled, then IDLE
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("rel1_cpu_rst", cpu_rst, 1);
        check("rel1_cpu_ce", cpu_ce, 1);
        check("rel1_cmd_ready", cmd_ready, 0);
        @(negedge CLK);
        check("rel2_cpu_rst", cpu_rst, 1);
        check("rel2_cmd_ready", cmd_ready, 0);
        @(negedge CLK);
        check("rel3_cmd_ready", cmd_ready, 1);
        check("rel3_halted", halted, 1);
        check("rel3_cpu_rst", cpu_rst, 0);
        check("rel3_cpu_ce", cpu_ce, 0);
        check("rel3_pc", PC_Value, 0);
        exp_pc = 32'h0;

        // Breakpoint at 0x10 on slot 0; slot 1 sits at 0x08 but is disabled
        bp_addr = {32'h0000_0008, 32'h0000_0010};
        bp_en   = 2'b01;
        ce_acc = 0;
        send(OP_RUN_BP, 0);
        run_until_idle(50, cyc);
        check("bp_cycles", cyc, 5);
        check("bp_ce_count", ce_acc, 4);
        check("bp_stop_pc", PC_Value, 32'h10);
        check("bp_hit", bp_hit, 2'b01);
        check("bp_steps_done", steps_done, 4);

        // Resume from the breakpoint with a 3-cycle timeout
        ce_acc = 0;
        send(OP_RUN_BP, 3);
        check("bp_resume_ce_first", cpu_ce, 1);
        run_until_idle(50, cyc);
        check("bp_resume_ce_count", ce_acc, 3);
        check("bp_resume_pc", PC_Value, 32'h1C);
        check("bp_timeout_hit", bp_hit, 0);
        exp_pc = 32'h1C;

        // Single step
        ce_acc = 0;
        send(OP_STEP, 0);
        check("step_ce_t1", cpu_ce, 1);
        check("step_sd_clear", steps_done, 0);
        check("step_halted_t1", halted, 0);
        tick();
        check("step_halted_t2", halted, 1);
        check("step_steps_done", steps_done, 1);
        check("step_ce_count", ce_acc, 1);
        exp_pc += 32'd4;

        // RUN_N 5 then RUN_N 0
        ce_acc = 0;
        send(OP_RUN_N, 5);
        run_until_idle(50, cyc);
        check("run5_cycles", cyc, 5);
        check("run5_ce_count", ce_acc, 5);
        check("run5_steps_done", steps_done, 5);
        exp_pc += 32'd20;
        ce_acc = 0;
        send(OP_RUN_N, 0);
        check("run0_halted", halted, 1);
        tick(); tick();
        check("run0_ce_count", ce_acc, 0);
        check("run0_steps_done", steps_done, 5);

        // HALT while idle
        send(OP_HALT, 0);
        check("halt_idle_err", cmd_err, 0);
        check("halt_idle_halted", halted, 1);

        // RUN_N 100, STEP mid-run is discarded, HALT accepted in cycle 10
        ce_acc = 0;
        send(OP_RUN_N, 100);
        repeat (4) tick();
        send(OP_STEP, 0);
        check("midrun_cmd_err", cmd_err, 1);
        check("midrun_still_running", halted, 0);
        repeat (4) tick();
        send(OP_HALT, 0);
        check("halt_ce_low", cpu_ce, 0);
        check("halt_halted", halted, 1);
        check("halt_ce_count", ce_acc, 10);
        check("halt_no_err", cmd_err, 0);
        exp_pc += 32'd40;
        check("halt_pc", PC_Value, exp_pc);

        // Random commands against the reference model
        sd_exp  = steps_done;
        hit_exp = bp_hit;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            ce_acc = 0;
            steps = 0;
            if (sel < 3) begin
                send(OP_STEP, 0);
                run_until_idle(50, cyc);
                steps = 1; sd_exp = 1; hit_exp = 2'b00;
                check("rnd_step_cycles", cyc, 1);
            end else if (sel < 6) begin
                n = $urandom_range(0, 12);
                send(OP_RUN_N, n);
                run_until_idle(50, cyc);
                steps = n;
                if (n > 0) begin sd_exp = CNT_W'(n); hit_exp = 2'b00; end
                check("rnd_runn_cycles", cyc, n);
            end else if (sel < 9) begin
                a0  = exp_pc + 32'(4 * $urandom_range(0, 12));
                a1  = exp_pc + 32'(4 * $urandom_range(0, 12));
                en  = 2'($urandom_range(0, 3));
                tmo = $urandom_range(0, 20);
                steps = bp_model(exp_pc, a0, a1, en, tmo, hit_m);
                if (steps < 0) begin
                    tmo = 9;
                    steps = bp_model(exp_pc, a0, a1, en, tmo, hit_m);
                end
                bp_addr = {a1, a0};
                bp_en   = en;
                send(OP_RUN_BP, tmo);
                run_until_idle(100, cyc);
                sd_exp = CNT_W'(steps); hit_exp = hit_m;
                check("rnd_runbp_cycles", cyc, steps + ((hit_m != 2'b00) ? 1 : 0));
            end else begin
                send(OP_HALT, 0);
                check("rnd_halt_err", cmd_err, 0);
            end
            exp_pc += 32'(4 * steps);
            check("rnd_ce_count", ce_acc, steps);
            check("rnd_steps_done", steps_done, sd_exp);
            check("rnd_bp_hit", bp_hit, hit_exp);
            check("rnd_pc", PC_Value, exp_pc);
        end

        // Reset asserted in the middle of an unlimited RUN_BP
        bp_en = 2'b00;
        send(OP_RUN_BP, 0);
        repeat (3) tick();
        check("abort_pre_ce", cpu_ce, 1);
        RST = 1'b1;
        #1;
        check("abort_cpu_ce", cpu_ce, 0);
        check("abort_cpu_rst", cpu_rst, 1);
        check("abort_bp_hit", bp_hit, 0);
        check("abort_halted", halted, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        @(negedge CLK);
        check("abort_steps_done", steps_done, 0);
        check("abort_cmd_err", cmd_err, 0);
        @(posedge CLK); #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rerel_halted", halted, 1);
        check("rerel_pc", PC_Value, 0);
        check("rerel_cmd_err", cmd_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
